// File: rtl/mem_block_streamer_pkg.sv
// Shared sizes, state encoding and address arithmetic for the block streamer.
package mem_block_streamer_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BLK_WORDS = 16;
    localparam int unsigned DEPTH     = 512;
    localparam int unsigned ADDR_W    = 9;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned BLK_W     = WORD_W * BLK_WORDS;

    localparam logic MODE_RD = 1'b0;
    localparam logic MODE_WR = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD_FETCH,
        RD_HOLD,
        WR_WAIT,
        WR_COMMIT,
        DONE
    } state_t;

    // Start address of the following block, wrapping at the end of memory.
    function automatic logic [ADDR_W-1:0] next_blk_addr(input logic [ADDR_W-1:0] addr);
        return ADDR_W'((32'(addr) + BLK_WORDS) % DEPTH);
    endfunction

endpackage

// File: rtl/mem_block_streamer_if.sv
// Control, stream and memory-port bundle for mem_block_streamer.
interface mem_block_streamer_if;
    import mem_block_streamer_pkg::*;

    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_blocks;
    logic              busy;
    logic              done;

    logic [BLK_W-1:0]  rd_data;
    logic              rd_valid;
    logic              rd_ready;

    logic [BLK_W-1:0]  wr_data;
    logic              wr_valid;
    logic              wr_ready;

    logic [ADDR_W-1:0] mem_addr;
    logic [BLK_W-1:0]  mem_wdata;
    logic              mem_we;
    logic [BLK_W-1:0]  mem_rdata;

    // Streamer side.
    modport master (
        input  start, mode, base_addr, num_blocks, rd_ready, wr_data, wr_valid, mem_rdata,
        output busy, done, rd_data, rd_valid, wr_ready, mem_addr, mem_wdata, mem_we
    );

    // Requester / producer / consumer / memory side.
    modport slave (
        output start, mode, base_addr, num_blocks, rd_ready, wr_data, wr_valid, mem_rdata,
        input  busy, done, rd_data, rd_valid, wr_ready, mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/mem_block_streamer_blk_addr_counter.sv
// Block address and remaining-block counter for a burst.
module blk_addr_counter
    import mem_block_streamer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  count,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [CNT_W-1:0] remaining;

    // Load on burst acceptance, step one block per completed transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= base;
            remaining <= count;
        end else if (advance) begin
            addr      <= next_blk_addr(addr);
            remaining <= remaining - CNT_W'(1);
        end
    end

    assign last = (remaining == CNT_W'(1));

endmodule

// File: rtl/mem_block_streamer.sv
// Burst sequencer moving 16-word blocks between block memory and valid/ready streams.
module mem_block_streamer
    import mem_block_streamer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    mem_block_streamer_if.master bus
);

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic              last_blk;
    logic              load;
    logic              advance;
    logic              we_q;

    assign load    = (state == IDLE) && bus.start;
    assign advance = ((state == RD_HOLD) && bus.rd_ready) || (state == WR_COMMIT);

    blk_addr_counter u_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .base    (bus.base_addr),
        .count   (bus.num_blocks),
        .advance (advance),
        .addr    (cur_addr),
        .last    (last_blk)
    );

    assign bus.mem_addr = cur_addr;
    // The write strobe is masked by reset in the same cycle so an aborted
    // commit never reaches the memory's falling-edge write.
    assign bus.mem_we   = we_q && !reset;

    // Burst state machine with registered handshake and datapath outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.rd_valid  <= 1'b0;
            bus.rd_data   <= '0;
            bus.wr_ready  <= 1'b0;
            bus.mem_wdata <= '0;
            we_q          <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.num_blocks == '0) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else if (bus.mode == MODE_RD) begin
                            state    <= RD_FETCH;
                            bus.busy <= 1'b1;
                        end else begin
                            state        <= WR_WAIT;
                            bus.busy     <= 1'b1;
                            bus.wr_ready <= 1'b1;
                        end
                    end
                end
                RD_FETCH: begin
                    bus.rd_data  <= bus.mem_rdata;
                    bus.rd_valid <= 1'b1;
                    state        <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (bus.rd_ready) begin
                        bus.rd_valid <= 1'b0;
                        if (last_blk) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                        end else begin
                            state <= RD_FETCH;
                        end
                    end
                end
                WR_WAIT: begin
                    if (bus.wr_valid) begin
                        bus.mem_wdata <= bus.wr_data;
                        bus.wr_ready  <= 1'b0;
                        we_q          <= 1'b1;
                        state         <= WR_COMMIT;
                    end
                end
                WR_COMMIT: begin
                    we_q <= 1'b0;
                    if (last_blk) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end else begin
                        state        <= WR_WAIT;
                        bus.wr_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_block_streamer.sv
// Scoreboard bench for mem_block_streamer with a 512x32 block-memory model.
module tb_mem_block_streamer;
    import mem_block_streamer_pkg::*;

    logic clk = 1'b0;
    logic reset;

    mem_block_streamer_if bus ();

    mem_block_streamer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [WORD_W-1:0] mem [DEPTH];
    int unsigned       fill_seq  = 0;
    int unsigned       fill_seen = 0;
    logic              fill_kind = 1'b0;
    logic [ADDR_W-1:0] we_log [$];
    int                done_cnt  = 0;
    logic [BLK_W-1:0]  rd_exp [$];
    logic [ADDR_W-1:0] wa_exp [$];
    int                tests = 0;
    int                fails = 0;

    // Combinational block read with word wrap inside the block.
    always_comb begin
        bus.mem_rdata = '0;
        for (int i = 0; i < int'(BLK_WORDS); i++)
            bus.mem_rdata[WORD_W*i +: WORD_W] = mem[ADDR_W'(int'(bus.mem_addr) + i)];
    end

    // Memory fill requests, falling-edge block writes and event logging.
    always @(negedge clk) begin
        if (fill_seq != fill_seen) begin
            for (int k = 0; k < int'(DEPTH); k++)
                mem[ADDR_W'(k)] = fill_kind ? (32'hDEAD_0000 | 32'(k)) : 32'(k);
            fill_seen = fill_seq;
        end
        if (bus.mem_we) begin
            for (int i = 0; i < int'(BLK_WORDS); i++)
                mem[ADDR_W'(int'(bus.mem_addr) + i)] = bus.mem_wdata[WORD_W*i +: WORD_W];
            we_log.push_back(bus.mem_addr);
        end
        if (bus.done) done_cnt++;
    end

    function automatic logic [BLK_W-1:0] ramp_blk(input int unsigned a);
        logic [BLK_W-1:0] b;
        for (int i = 0; i < int'(BLK_WORDS); i++)
            b[WORD_W*i +: WORD_W] = 32'((a + 32'(i)) % DEPTH);
        return b;
    endfunction

    function automatic logic [BLK_W-1:0] pat_blk(input logic [WORD_W-1:0] seed);
        logic [BLK_W-1:0] b;
        for (int i = 0; i < int'(BLK_WORDS); i++)
            b[WORD_W*i +: WORD_W] = seed + 32'(i);
        return b;
    endfunction

    task automatic fill_mem(input logic kind);
        fill_kind = kind;
        fill_seq++;
        @(negedge clk);
        #1;
    endtask

    task automatic start_burst(input logic m, input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
        bus.start      = 1'b1;
        bus.mode       = m;
        bus.base_addr  = b;
        bus.num_blocks = n;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.done); end
        tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
        tests++; if (bus.wr_ready !== 1'b0) begin fails++; $display("FAIL reset_wr_ready: got %b want 0", bus.wr_ready); end
        tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
        tests++; if (bus.mem_addr !== '0) begin fails++; $display("FAIL reset_mem_addr: got %0d want 0", bus.mem_addr); end
        tests++; if (bus.rd_data !== '0) begin fails++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
        tests++; if (bus.mem_wdata !== '0) begin fails++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_read_burst();
        int first_valid;
        int done_at;
        int got;
        int done0;
        first_valid = -1; done_at = -1; got = 0; done0 = done_cnt;
        fill_mem(1'b0);
        for (int b = 0; b < 2; b++) rd_exp.push_back(ramp_blk(32'(16 * b)));
        bus.rd_ready = 1'b1;
        start_burst(MODE_RD, 9'd0, 6'd2);
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL rd_busy_rise: got %b want 1", bus.busy); end
        for (int c = 1; c <= 20 && done_at < 0; c++) begin
            @(posedge clk);
            #1;
            if (bus.rd_valid === 1'b1) begin
                if (first_valid < 0) first_valid = c;
                got++;
                tests++;
                if (rd_exp.size() == 0) begin
                    fails++; $display("FAIL rd_extra_block: got %h want none", bus.rd_data);
                end else begin
                    logic [BLK_W-1:0] e;
                    e = rd_exp.pop_front();
                    if (bus.rd_data !== e) begin fails++; $display("FAIL rd_data: got %h want %h", bus.rd_data, e); end
                end
            end
            if (bus.done === 1'b1) begin
                done_at = c;
                tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rd_busy_with_done: got %b want 0", bus.busy); end
            end
        end
        // Accepting edge is edge 0; first block appears two cycles after start was raised.
        tests++; if (first_valid != 1) begin fails++; $display("FAIL rd_latency: got %0d want 1", first_valid); end
        tests++; if (got != 2) begin fails++; $display("FAIL rd_block_count: got %0d want 2", got); end
        tests++; if (done_at != 4) begin fails++; $display("FAIL rd_done_cycle: got %0d want 4", done_at); end
        @(posedge clk);
        #1;
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL rd_done_width: got %b want 0", bus.done); end
        tests++; if (done_cnt - done0 != 1) begin fails++; $display("FAIL rd_done_pulses: got %0d want 1", done_cnt - done0); end
        rd_exp.delete();
    endtask

    task automatic test_backpressure();
        logic [BLK_W-1:0] e;
        bit fin;
        fin = 1'b0;
        rd_exp.push_back(ramp_blk(32));
        rd_exp.push_back(ramp_blk(48));
        bus.rd_ready = 1'b0;
        start_burst(MODE_RD, 9'd32, 6'd2);
        for (int c = 0; c < 10 && bus.rd_valid !== 1'b1; c++) begin @(posedge clk); #1; end
        tests++; if (bus.rd_valid !== 1'b1) begin fails++; $display("FAIL bp_first_valid: got %b want 1", bus.rd_valid); end
        e = rd_exp.pop_front();
        tests++; if (bus.rd_data !== e) begin fails++; $display("FAIL bp_data0: got %h want %h", bus.rd_data, e); end
        for (int s = 0; s < 5; s++) begin
            @(posedge clk);
            #1;
            tests++; if (bus.rd_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid: got %b want 1", bus.rd_valid); end
            tests++; if (bus.rd_data !== e) begin fails++; $display("FAIL bp_hold_data: got %h want %h", bus.rd_data, e); end
            tests++; if (bus.mem_addr !== 9'd32) begin fails++; $display("FAIL bp_hold_addr: got %0d want 32", bus.mem_addr); end
        end
        bus.rd_ready = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL bp_accept_valid: got %b want 0", bus.rd_valid); end
        tests++; if (bus.mem_addr !== 9'd48) begin fails++; $display("FAIL bp_accept_addr: got %0d want 48", bus.mem_addr); end
        for (int c = 0; c < 10 && bus.rd_valid !== 1'b1; c++) begin @(posedge clk); #1; end
        e = rd_exp.pop_front();
        tests++; if (bus.rd_data !== e || bus.rd_valid !== 1'b1) begin fails++; $display("FAIL bp_data1: got %h want %h", bus.rd_data, e); end
        for (int c = 0; c < 5 && !fin; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) fin = 1'b1;
        end
        tests++; if (!fin) begin fails++; $display("FAIL bp_done: got 0 want 1"); end
        @(posedge clk);
        #1;
        rd_exp.delete();
    endtask

    task automatic test_zero_len();
        int we0;
        int done0;
        we0 = we_log.size(); done0 = done_cnt;
        start_burst(MODE_RD, 9'd100, 6'd0);
        tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL zl_rd_done: got %b want 1", bus.done); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL zl_rd_busy: got %b want 0", bus.busy); end
        tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL zl_rd_valid: got %b want 0", bus.rd_valid); end
        @(posedge clk);
        #1;
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL zl_done_width: got %b want 0", bus.done); end
        start_burst(MODE_WR, 9'd7, 6'd0);
        tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL zl_wr_done: got %b want 1", bus.done); end
        tests++; if (bus.wr_ready !== 1'b0) begin fails++; $display("FAIL zl_wr_ready: got %b want 0", bus.wr_ready); end
        @(posedge clk);
        #1;
        tests++; if (we_log.size() != we0) begin fails++; $display("FAIL zl_no_we: got %0d want %0d", we_log.size(), we0); end
        tests++; if (done_cnt - done0 != 2) begin fails++; $display("FAIL zl_done_pulses: got %0d want 2", done_cnt - done0); end
    endtask

    task automatic test_ignored_start();
        int got;
        bit fin;
        got = 0; fin = 1'b0;
        rd_exp.push_back(ramp_blk(128));
        rd_exp.push_back(ramp_blk(144));
        bus.rd_ready = 1'b0;
        start_burst(MODE_RD, 9'd128, 6'd2);
        for (int c = 0; c < 10 && bus.rd_valid !== 1'b1; c++) begin @(posedge clk); #1; end
        start_burst(MODE_WR, 9'd300, 6'd5);
        tests++; if (bus.rd_valid !== 1'b1) begin fails++; $display("FAIL ig_valid: got %b want 1", bus.rd_valid); end
        tests++; if (bus.mem_addr !== 9'd128) begin fails++; $display("FAIL ig_addr: got %0d want 128", bus.mem_addr); end
        tests++; if (bus.wr_ready !== 1'b0) begin fails++; $display("FAIL ig_wr_ready: got %b want 0", bus.wr_ready); end
        bus.rd_ready = 1'b1;
        for (int c = 0; c < 20 && !fin; c++) begin
            if (bus.rd_valid === 1'b1) begin
                got++;
                tests++;
                if (rd_exp.size() == 0) begin
                    fails++; $display("FAIL ig_extra_block: got %h want none", bus.rd_data);
                end else begin
                    logic [BLK_W-1:0] e;
                    e = rd_exp.pop_front();
                    if (bus.rd_data !== e) begin fails++; $display("FAIL ig_data: got %h want %h", bus.rd_data, e); end
                end
            end
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) fin = 1'b1;
        end
        tests++; if (got != 2) begin fails++; $display("FAIL ig_block_count: got %0d want 2", got); end
        tests++; if (!fin) begin fails++; $display("FAIL ig_done: got 0 want 1"); end
        // A start offered during the done cycle must not open a new burst.
        start_burst(MODE_RD, 9'd0, 6'd1);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL ig_start_in_done: got busy %b want 0", bus.busy); end
        @(posedge clk);
        #1;
        tests++; if (bus.busy !== 1'b0 || bus.rd_valid !== 1'b0) begin fails++; $display("FAIL ig_idle_after: got busy %b valid %b want 0 0", bus.busy, bus.rd_valid); end
        rd_exp.delete();
    endtask

    task automatic test_write_wrap();
        int we0;
        int j;
        bit fin;
        bit hs;
        we0 = we_log.size(); j = 0; fin = 1'b0;
        fill_mem(1'b1);
        wa_exp.delete();
        wa_exp.push_back(9'd504);
        wa_exp.push_back(9'd8);
        start_burst(MODE_WR, 9'd504, 6'd2);
        bus.wr_valid = 1'b1;
        bus.wr_data  = pat_blk(32'hA000_0000);
        for (int c = 0; c < 40 && !fin; c++) begin
            hs = (bus.wr_ready === 1'b1) && (bus.wr_valid === 1'b1);
            @(posedge clk);
            #1;
            if (hs) begin
                j++;
                if (j < 2) bus.wr_data = pat_blk(32'hB000_0000);
                else bus.wr_valid = 1'b0;
            end
            if (bus.done === 1'b1) fin = 1'b1;
        end
        bus.wr_valid = 1'b0;
        tests++; if (!fin) begin fails++; $display("FAIL wr_done: got 0 want 1"); end
        tests++; if (we_log.size() - we0 != 2) begin fails++; $display("FAIL wr_we_pulses: got %0d want 2", we_log.size() - we0); end
        for (int k = 0; k < 2 && we0 + k < we_log.size(); k++) begin
            logic [ADDR_W-1:0] ea;
            ea = wa_exp.pop_front();
            tests++; if (we_log[we0 + k] !== ea) begin fails++; $display("FAIL wr_we_addr: got %0d want %0d", we_log[we0 + k], ea); end
        end
        for (int i = 0; i < 16; i++) begin
            tests++; if (mem[ADDR_W'(504 + i)] !== 32'hA000_0000 + 32'(i)) begin fails++; $display("FAIL wr_blockA: got %h want %h", mem[ADDR_W'(504 + i)], 32'hA000_0000 + 32'(i)); end
            tests++; if (mem[ADDR_W'(8 + i)] !== 32'hB000_0000 + 32'(i)) begin fails++; $display("FAIL wr_blockB: got %h want %h", mem[ADDR_W'(8 + i)], 32'hB000_0000 + 32'(i)); end
        end
        tests++; if (mem[503] !== 32'hDEAD_01F7) begin fails++; $display("FAIL wr_below: got %h want DEAD01F7", mem[503]); end
        tests++; if (mem[24] !== 32'hDEAD_0018) begin fails++; $display("FAIL wr_above: got %h want DEAD0018", mem[24]); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_write();
        int we0;
        int done0;
        int j;
        bit hit;
        bit hs;
        we0 = we_log.size(); done0 = done_cnt; j = 0; hit = 1'b0;
        fill_mem(1'b1);
        start_burst(MODE_WR, 9'd64, 6'd4);
        bus.wr_valid = 1'b1;
        bus.wr_data  = pat_blk(32'hA000_0000);
        for (int c = 0; c < 40 && !hit; c++) begin
            hs = (bus.wr_ready === 1'b1) && (bus.wr_valid === 1'b1);
            @(posedge clk);
            #1;
            if (hs) begin
                j++;
                if (j == 2) hit = 1'b1;
                else bus.wr_data = pat_blk(32'hB000_0000);
            end
        end
        tests++; if (!hit || bus.mem_we !== 1'b1) begin fails++; $display("FAIL rst_reach_commit: got hit %b we %b want 1 1", hit, bus.mem_we); end
        reset = 1'b1;
        bus.wr_valid = 1'b0;
        #1;
        tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL rst_we_in_cycle: got %b want 0", bus.mem_we); end
        @(posedge clk);
        #1;
        tests++; if ({bus.busy, bus.done, bus.rd_valid, bus.wr_ready, bus.mem_we} !== 5'b0) begin fails++; $display("FAIL rst_flags: got %b want 00000", {bus.busy, bus.done, bus.rd_valid, bus.wr_ready, bus.mem_we}); end
        tests++; if (bus.mem_addr !== '0) begin fails++; $display("FAIL rst_addr: got %0d want 0", bus.mem_addr); end
        tests++; if (bus.rd_data !== '0 || bus.mem_wdata !== '0) begin fails++; $display("FAIL rst_data: got rd %h wd %h want 0", bus.rd_data, bus.mem_wdata); end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            tests++; if (bus.done !== 1'b0 || bus.mem_we !== 1'b0) begin fails++; $display("FAIL rst_quiet: got done %b we %b want 0 0", bus.done, bus.mem_we); end
        end
        tests++; if (done_cnt != done0) begin fails++; $display("FAIL rst_no_done: got %0d want %0d", done_cnt - done0, 0); end
        tests++; if (we_log.size() - we0 != 1) begin fails++; $display("FAIL rst_we_pulses: got %0d want 1", we_log.size() - we0); end
        tests++; if (mem[64] !== 32'hA000_0000 || mem[79] !== 32'hA000_000F) begin fails++; $display("FAIL rst_block1: got %h %h want A0000000 A000000F", mem[64], mem[79]); end
        tests++; if (mem[80] !== 32'hDEAD_0050 || mem[95] !== 32'hDEAD_005F) begin fails++; $display("FAIL rst_block2: got %h %h want DEAD0050 DEAD005F", mem[80], mem[95]); end
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.mode       = 1'b0;
        bus.base_addr  = '0;
        bus.num_blocks = '0;
        bus.rd_ready   = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        test_reset();
        test_read_burst();
        test_backpressure();
        test_zero_len();
        test_ignored_start();
        test_write_wrap();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
